// File: rtl/probe_cap_pkg.sv
// Shared types and constants for the probe_cap debug capture block.
// Optional timestamping is enabled by defining PROBE_CAP_TIMESTAMP_EN.
package probe_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        POST    = 2'd2,
        READOUT = 2'd3
    } state_t;

    localparam int TS_W = 32;

    function automatic int sample_width(input int width, input int nch, input int ch_w);
        return width + nch * ch_w;
    endfunction

endpackage

// File: rtl/probe_cap_if.sv
// Bus bundle for probe_cap: observed data, probe channels, trigger setup and read port.
// rd_ts exists only when PROBE_CAP_TIMESTAMP_EN is defined.
interface probe_cap_if #(
    parameter int WIDTH = 64,
    parameter int NCH   = 13,
    parameter int CH_W  = 13,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]          data_in;
    logic [WIDTH-1:0]          data_out;
    logic [NCH*CH_W-1:0]       ch_in;
    logic [NCH-1:0]            inv_mask;
    logic [WIDTH-1:0]          trig_value;
    logic [WIDTH-1:0]          trig_mask;
    logic [AW-1:0]             pre_count;
    logic                      arm;
    logic [1:0]                state;
    // Read port: a word moves on a rising edge where rd_valid and rd_ready are both high;
    // while rd_valid is high and rd_ready low, rd_data/rd_last/rd_valid hold unchanged.
    logic                      rd_valid;
    logic                      rd_ready;
    logic [WIDTH+NCH*CH_W-1:0] rd_data;
    logic                      rd_last;
`ifdef PROBE_CAP_TIMESTAMP_EN
    logic [probe_cap_pkg::TS_W-1:0] rd_ts;
`endif

    modport master (
        output data_in, ch_in, inv_mask, trig_value, trig_mask, pre_count, arm, rd_ready,
        input  data_out, state, rd_valid, rd_data, rd_last
`ifdef PROBE_CAP_TIMESTAMP_EN
        , input rd_ts
`endif
    );

    modport slave (
        input  data_in, ch_in, inv_mask, trig_value, trig_mask, pre_count, arm, rd_ready,
        output data_out, state, rd_valid, rd_data, rd_last
`ifdef PROBE_CAP_TIMESTAMP_EN
        , output rd_ts
`endif
    );

endinterface

// File: rtl/probe_cap_ram.sv
// Simple dual-port capture buffer: one write port, one read port with registered output.
// The output register only updates on a read, so it holds while the reader stalls.
module probe_cap_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/probe_cap.sv
// Debug probe capture: 2-stage data pass-through, inverted probe channels, pre/post trigger
// circular capture and in-order readout. PROBE_CAP_TIMESTAMP_EN adds a per-sample timestamp.
module probe_cap
    import probe_cap_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NCH   = 13,
    parameter int CH_W  = 13,
    parameter int DEPTH = 256
) (
    input logic        clk,
    input logic        rst,
    probe_cap_if.slave bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CHB = NCH * CH_W;
    localparam int SW  = sample_width(WIDTH, NCH, CH_W);
`ifdef PROBE_CAP_TIMESTAMP_EN
    localparam int MW  = SW + TS_W;
`else
    localparam int MW  = SW;
`endif

    logic [WIDTH-1:0] s_data;
    logic [CHB-1:0]   s_ch;
    logic [WIDTH-1:0] d2;
    logic [CHB-1:0]   ch_inv;

    state_t           state_q, state_n;
    logic [AW-1:0]    pre_lat;
    logic [AW:0]      fill;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    trig_ptr;
    logic [AW-1:0]    post_cnt;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      issued;
    logic             rd_valid_q;
    logic             rd_last_q;

    logic             hit, qual, we, re, to_readout;
    logic [AW-1:0]    post_init;
    logic [AW-1:0]    trig_ptr_n;
    logic [MW-1:0]    wdata, rdata;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_inv[i*CH_W +: CH_W] = bus.ch_in[i*CH_W +: CH_W] ^ {CH_W{bus.inv_mask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_data <= '0;
            s_ch   <= '0;
            d2     <= '0;
        end else begin
            s_data <= bus.data_in;
            s_ch   <= ch_inv;
            d2     <= s_data;
        end
    end

    assign hit        = ((s_data ^ bus.trig_value) & bus.trig_mask) == '0;
    assign qual       = hit && (fill >= {1'b0, pre_lat});
    assign post_init  = AW'(DEPTH - 1) - pre_lat;
    assign we         = (state_q == ARMED) || (state_q == POST);
    assign re         = (state_q == READOUT) && (issued != (AW+1)'(DEPTH))
                        && (!rd_valid_q || bus.rd_ready);
    assign trig_ptr_n = (state_q == ARMED) ? wr_ptr : trig_ptr;
    assign to_readout = (state_n == READOUT) && (state_q != READOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (bus.arm) state_n = ARMED;
            ARMED:   if (qual) state_n = (post_init == '0) ? READOUT : POST;
            POST:    if (post_cnt == AW'(1)) state_n = READOUT;
            READOUT: if (rd_valid_q && bus.rd_ready && rd_last_q) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // pre_count is AW bits wide, so it can never exceed DEPTH-1 and needs no clamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_lat    <= '0;
            fill       <= '0;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            post_cnt   <= '0;
            rd_ptr     <= '0;
            issued     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.arm) begin
                pre_lat <= bus.pre_count;
                fill    <= '0;
            end
            if (we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (state_q == ARMED && fill != (AW+1)'(DEPTH)) begin
                fill <= fill + (AW+1)'(1);
            end
            if (state_q == ARMED && qual) begin
                trig_ptr <= wr_ptr;
                post_cnt <= post_init;
            end else if (state_q == POST) begin
                post_cnt <= post_cnt - AW'(1);
            end
            if (to_readout) begin
                rd_ptr <= trig_ptr_n - pre_lat;
                issued <= '0;
            end else if (re) begin
                rd_ptr <= rd_ptr + AW'(1);
                issued <= issued + (AW+1)'(1);
            end
            // RAM output lands one cycle after the read is issued, together with rd_valid.
            if (re) begin
                rd_valid_q <= 1'b1;
                rd_last_q  <= (issued == (AW+1)'(DEPTH - 1));
            end else if (rd_valid_q && bus.rd_ready) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end

`ifdef PROBE_CAP_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    assign wdata     = {ts, s_ch, s_data};
    assign bus.rd_ts = rdata[MW-1 -: TS_W];
    assign bus.rd_data = rdata[SW-1:0];
`else
    assign wdata       = {s_ch, s_data};
    assign bus.rd_data = rdata;
`endif

    probe_cap_ram #(.DEPTH(DEPTH), .W(MW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.data_out = d2;
    assign bus.state    = state_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;

endmodule

// File: tb/tb_probe_cap.sv
// Directed bench for probe_cap with WIDTH=8, NCH=2, CH_W=4, DEPTH=16.
module tb_probe_cap;

    localparam int WIDTH = 8;
    localparam int NCH   = 2;
    localparam int CH_W  = 4;
    localparam int DEPTH = 16;
    localparam int SW    = WIDTH + NCH * CH_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [SW-1:0] exp_q[$];

    probe_cap_if #(.WIDTH(WIDTH), .NCH(NCH), .CH_W(CH_W), .DEPTH(DEPTH)) bus ();

    probe_cap #(.WIDTH(WIDTH), .NCH(NCH), .CH_W(CH_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Arm, ramp data_in from 0 until READOUT, then drain and score the window.
    // Optionally switches trig_value from tv to tv2 when the ramp reaches 7.
    task automatic capture(input int pre, input logic [7:0] tv, input logic [7:0] tv2,
                           input logic [7:0] tm, input int base, input logic [7:0] ch_exp,
                           input bit stall);
        logic [3:0]    pat;
        logic          held;
        logic [SW-1:0] held_data;
        logic          held_last;
        int            got;
        int            used;
        pat  = 4'b1001;
        held = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        got  = 0;
        used = 0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({ch_exp, 8'(base + i)});

        bus.pre_count  = 4'(pre);
        bus.trig_value = tv;
        bus.trig_mask  = tm;
        bus.rd_ready   = 1'b0;
        bus.data_in    = 8'd0;
        bus.arm        = 1'b1;
        cyc();
        bus.arm = 1'b0;
        check("armed", 64'(bus.state), 64'd1);
        for (int n = 0; n < 100; n++) begin
            bus.data_in = bus.data_in + 8'd1;
            if (bus.data_in == 8'd7 && tv2 != tv) begin
                check("early_hit_ignored", 64'(bus.state), 64'd1);
                bus.trig_value = tv2;
            end
            cyc();
            if (bus.state == 2'd3) break;
        end
        check("reach_readout", 64'(bus.state), 64'd3);
        if (bus.state != 2'd3) return;
        check("first_rd_valid_low", 64'(bus.rd_valid), 64'd0);

        for (int c = 0; c < 200 && got < DEPTH; c++) begin
            bus.rd_ready = stall ? pat[3 - (c % 4)] : 1'b1;
            if (held) begin
                check("stall_valid", 64'(bus.rd_valid), 64'd1);
                check("stall_data", 64'(bus.rd_data), 64'(held_data));
                check("stall_last", 64'(bus.rd_last), 64'(held_last));
                held = 1'b0;
            end
            if (bus.rd_valid) begin
                if (bus.rd_ready) begin
                    check("rd_data", 64'(bus.rd_data), 64'(exp_q.pop_front()));
                    check("rd_last", 64'(bus.rd_last), 64'(got == DEPTH - 1));
                    got++;
                end else begin
                    held      = 1'b1;
                    held_data = bus.rd_data;
                    held_last = bus.rd_last;
                end
            end
            cyc();
            used++;
        end
        bus.rd_ready = 1'b0;
        check("word_count", 64'(got), 64'(DEPTH));
        if (!stall) check("throughput", 64'(used), 64'(DEPTH + 1));
        check("idle_after_read", 64'(bus.state), 64'd0);
        check("rd_valid_after_read", 64'(bus.rd_valid), 64'd0);
    endtask

    initial begin
        logic [7:0] last_applied;
        bus.data_in    = '0;
        bus.ch_in      = '0;
        bus.inv_mask   = '0;
        bus.trig_value = '0;
        bus.trig_mask  = '0;
        bus.pre_count  = '0;
        bus.arm        = 1'b0;
        bus.rd_ready   = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        check("rst_data_out", 64'(bus.data_out), 64'd0);
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        check("rst_rd_last", 64'(bus.rd_last), 64'd0);

        // Pass-through ramp, no arm.
        last_applied = 8'd0;
        for (int i = 0; i < 20; i++) begin
            bus.data_in = 8'(i);
            cyc();
            check("data_out", 64'(bus.data_out), 64'(last_applied));
            last_applied = 8'(i);
        end
        check("noarm_state", 64'(bus.state), 64'd0);
        check("noarm_rd_valid", 64'(bus.rd_valid), 64'd0);

        // Trigger on 20 with 4 pre-trigger samples: window 16..31.
        capture(4, 8'd20, 8'd20, 8'hFF, 16, 8'h00, 1'b0);

        // Early hit at fill 2 ignored, then retarget to 9: window 5..20.
        capture(4, 8'd2, 8'd9, 8'hFF, 5, 8'h00, 1'b0);

        // Channel inversion: ch_in A5 with channel 0 inverted reads AA.
        bus.inv_mask = 2'b01;
        bus.ch_in    = 8'hA5;
        capture(4, 8'd20, 8'd20, 8'hFF, 16, 8'hAA, 1'b0);
        bus.inv_mask = 2'b00;
        bus.ch_in    = 8'h00;

        // Reader stalls with rd_ready pattern 1,0,0,1.
        capture(4, 8'd20, 8'd20, 8'hFF, 16, 8'h00, 1'b1);

        // All-zero mask with pre_count 15: trigger at fill 15, straight to READOUT, window 0..15.
        capture(15, 8'd77, 8'd77, 8'h00, 0, 8'h00, 1'b0);

        // Reset during POST, then a fresh capture.
        bus.pre_count  = 4'd4;
        bus.trig_value = 8'd20;
        bus.trig_mask  = 8'hFF;
        bus.data_in    = 8'd0;
        bus.arm        = 1'b1;
        cyc();
        bus.arm = 1'b0;
        for (int n = 0; n < 60; n++) begin
            bus.data_in = bus.data_in + 8'd1;
            cyc();
            if (bus.state == 2'd2) break;
        end
        check("reach_post", 64'(bus.state), 64'd2);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("post_rst_state", 64'(bus.state), 64'd0);
        check("post_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        capture(4, 8'd9, 8'd9, 8'hFF, 5, 8'h00, 1'b0);

        // rst and arm together: reset wins.
        rst     = 1'b1;
        bus.arm = 1'b1;
        cyc();
        rst     = 1'b0;
        bus.arm = 1'b0;
        check("rst_beats_arm", 64'(bus.state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/probe_cap.md
# probe_cap

Parametrised debug probe capture block: the next generation of the team's probe register. It keeps a registered data pass-through and adds a multi-channel probe bus with per-channel inversion. Samples go into a circular buffer with programmable pre-trigger depth and a masked-compare trigger. The captured window is then drained in chronological order over a valid/ready read port. It sits beside datapath blocks as a non-intrusive observation point.

## Interface
- WIDTH, 64: data pass-through and trigger-compare width
- NCH, 13: number of probe channels
- CH_W, 13: bits per probe channel
- DEPTH, 256: capture buffer depth in samples; power of two, ≥4
- clk  in  1  sole clock; everything is on the rising edge
- rst  in  1  reset, synchronous and active-high
- data_in  in  WIDTH  observed data
- data_out  out  WIDTH  data_in delayed 2 cycles
- ch_in  in  NCH*CH_W  packed probe channels, channel 0 at LSBs
- inv_mask  in  NCH  bit i set inverts channel i before sampling
- trig_value  in  WIDTH  trigger compare value
- trig_mask  in  WIDTH  compare enable per bit; all-zero gives an immediate trigger
- pre_count  in  $clog2(DEPTH)  samples retained before the trigger; latched on arm
- arm  in  1  single-cycle start request; ignored unless state is IDLE
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=READOUT
- rd_valid  out  1  read word valid
- rd_ready  in  1  read word accepted when both valid and ready are high
- rd_data  out  WIDTH+NCH*CH_W  sample word {channels, data}
- rd_last  out  1  high with the final word of the window

## Operation
- Sample stage S1, every cycle:
  - s_data <= data_in
  - s_ch <= ch_in with each channel XORed by its replicated inv_mask bit
- Stage S2: data_out <= s_data.
- Trigger hit: ((s_data ^ trig_value) & trig_mask) == 0, evaluated on S1.
- IDLE: no writes. arm latches pre_count (clamped to DEPTH-1) and clears the fill counter. Next state is ARMED.
- ARMED:
  - Each cycle, S1 {s_ch, s_data} is written at wr_ptr; wr_ptr increments modulo DEPTH; the fill counter saturates at DEPTH.
  - A hit is qualified only when fill ≥ latched pre_count, counted before this cycle's write.
  - A qualified hit writes the trigger sample, records trig_ptr, loads post = DEPTH-1-pre_count, and moves to POST.
  - If post == 0, go directly to READOUT.
- POST: write one sample per cycle and decrement post. The write that brings post to 0 moves the state to READOUT.
- READOUT:
  - No writes.
  - The read pointer starts at trig_ptr-pre_count modulo DEPTH.
  - Exactly DEPTH words are delivered; word index pre_count is the trigger sample.
  - After the word with rd_last is accepted, next state is IDLE.
- rd_valid is held high and rd_data/rd_last stay stable while rd_ready is low. Words are never dropped or repeated.
- Reset mid-operation, any state: return to IDLE, discard the window, deassert rd_valid.
- rst together with arm: rst wins.
- arm in any state other than IDLE has no effect.

## Timing
- Reset values: data_out=0, state=IDLE, rd_valid=0, rd_data=0, rd_last=0. S1/S2 registers, pointers and counters are 0.
- data_out latency: 2 cycles.
- Trigger latency: a hit on data_in at cycle t is evaluated at t+1. State reads POST at t+2.
- arm at cycle t: state is ARMED at t+1. The first written sample is S1 at t+1, which is data_in at t.
- RAM read latency is 1 cycle. rd_valid first asserts on the 2nd cycle in READOUT.
- With rd_ready held high, one word transfers per cycle.

## Configuration
- PROBE_CAP_TIMESTAMP_EN defined:
  - A 32-bit free-running counter, reset to 0, increments every cycle and wraps.
  - It is captured with each sample and presented on an extra output rd_ts (32 bits), aligned with rd_data.
- Not defined: no counter, no rd_ts port, and buffer word width is WIDTH+NCH*CH_W.

## Structure
- Package probe_cap_pkg holds:
  - the state enum (IDLE/ARMED/POST/READOUT, 2-bit encoding above)
  - the timestamp width constant (32)
  - a function returning the sample word width from WIDTH, NCH, CH_W
- Sub-module probe_cap_ram: simple dual-port buffer, one write port, registered read port, DEPTH x word width.

## Test plan
Bench parameters: WIDTH=8, NCH=2, CH_W=4, DEPTH=16.
- data_in ramps 0,1,2,… with no arm → data_out equals data_in from 2 cycles earlier; state stays 0; rd_valid stays 0.
- pre_count=4, trig_mask=FF, trig_value=20, ramp data_in from 0, arm at data 0 → 16 words read. Data values are 16..31, with word 4 = 20 and rd_last on word 15 (value 31).
- Same setup with trig_value=2 → hit at fill 2 is ignored. Since the ramp never returns to 2, the state stays ARMED. Set trig_value=9 instead → window is 5..20.
- inv_mask=2'b01, ch_in=8'hA5 during capture → the channel field of each sample reads 8'hAA.
- rd_ready toggling 1,0,0,1 during readout → rd_data is stable during stalls; all 16 words arrive in order with no duplicates.
- rst asserted in POST, then a new arm → state is IDLE the cycle after rst. The second capture completes with a correct, fresh window.
